// File: rtl/vscale_hasti_sram_mp_pkg.sv
// HASTI constants, port FSM states and transfer helpers
// shared by the multi-port SRAM slice.
package vscale_hasti_sram_mp_pkg;

  localparam logic [1:0] HASTI_TRANS_IDLE   = 2'd0;
  localparam logic [1:0] HASTI_TRANS_BUSY   = 2'd1;
  localparam logic [1:0] HASTI_TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HASTI_TRANS_SEQ    = 2'd3;

  localparam logic HASTI_RESP_OKAY  = 1'b0;
  localparam logic HASTI_RESP_ERROR = 1'b1;

  localparam logic [2:0] HASTI_SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ERR1,
    S_ERR2
  } port_state_e;

  function automatic logic is_xfer(logic [1:0] t);
    logic r;
    r = 1'b0;
    case (t)
      HASTI_TRANS_IDLE,
      HASTI_TRANS_BUSY:   r = 1'b0;
      HASTI_TRANS_NONSEQ,
      HASTI_TRANS_SEQ:    r = 1'b1;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_mask(
    logic [2:0] size,
    logic [1:0] off
  );
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'h1;
      3'd1:    m = 4'h3;
      default: m = 4'hF;
    endcase
    return m << off;
  endfunction

  function automatic logic is_legal(
    logic [2:0]  size,
    logic [31:0] addr,
    logic [31:0] nwords
  );
    logic al;
    case (size)
      3'd0:            al = 1'b1;
      3'd1:            al = ~addr[0];
      HASTI_SIZE_WORD: al = (addr[1:0] == 2'b00);
      default:         al = 1'b0;
    endcase
    return al && ({2'b00, addr[31:2]} < nwords);
  endfunction

endpackage

// File: rtl/vscale_hasti_sram_mp_if.sv
// Flattened per-port HASTI bus bundle; port i occupies
// slice i of every vector.
interface vscale_hasti_sram_mp_if #(
  parameter int NPORTS = 2
);
  logic [NPORTS*32-1:0] haddr;
  logic [NPORTS-1:0]    hwrite;
  logic [NPORTS*3-1:0]  hsize;
  logic [NPORTS*3-1:0]  hburst;
  logic [NPORTS-1:0]    hmastlock;
  logic [NPORTS*4-1:0]  hprot;
  logic [NPORTS*2-1:0]  htrans;
  logic [NPORTS*32-1:0] hwdata;
  logic [NPORTS*32-1:0] hrdata;
  logic [NPORTS-1:0]    hready;
  logic [NPORTS-1:0]    hresp;

  modport master (
    output haddr, hwrite, hsize, hburst,
    output hmastlock, hprot, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, hwrite, hsize, hburst,
    input  hmastlock, hprot, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/vscale_hasti_sram_port.sv
// One HASTI slave port: address-phase registers, legality
// check and the two-cycle error response FSM.
module vscale_hasti_sram_port
  import vscale_hasti_sram_mp_pkg::*;
#(
  parameter int NWORDS = 32,
  parameter int AW     = 5
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic [31:0]   haddr,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [1:0]    htrans,
  output logic          hready,
  output logic          hresp,
  output logic [AW-1:0] waddr,
  output logic [3:0]    wmask,
  output logic          wen,
  output logic          rvalid
);

  port_state_e state;
  logic        xfer;
  logic        legal;

  assign xfer  = is_xfer(htrans);
  assign legal = is_legal(hsize, haddr, 32'(NWORDS));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state  <= S_IDLE;
      hready <= 1'b1;
      hresp  <= HASTI_RESP_OKAY;
      waddr  <= '0;
      wmask  <= '0;
      wen    <= 1'b0;
      rvalid <= 1'b0;
    end else if (state == S_ERR1) begin
      // hready is low here, so the address bus is not sampled
      state  <= S_ERR2;
      hready <= 1'b1;
      hresp  <= HASTI_RESP_ERROR;
      wen    <= 1'b0;
      rvalid <= 1'b0;
    end else if (xfer && legal) begin
      state  <= S_DATA;
      hready <= 1'b1;
      hresp  <= HASTI_RESP_OKAY;
      waddr  <= haddr[AW+1:2];
      wmask  <= byte_mask(hsize, haddr[1:0]);
      wen    <= hwrite;
      rvalid <= ~hwrite;
    end else if (xfer) begin
      state  <= S_ERR1;
      hready <= 1'b0;
      hresp  <= HASTI_RESP_ERROR;
      wen    <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      state  <= S_IDLE;
      hready <= 1'b1;
      hresp  <= HASTI_RESP_OKAY;
      wen    <= 1'b0;
      rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/vscale_hasti_sram_mp.sv
// Multi-port zero-wait HASTI SRAM with byte-merged,
// lowest-port-wins simultaneous writes.
module vscale_hasti_sram_mp #(
  parameter int NPORTS = 2,
  parameter int NWORDS = 32
) (
  input logic                   hclk,
  input logic                   hresetn,
  vscale_hasti_sram_mp_if.slave bus
);

  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [31:0]       mem [NWORDS];
  logic [AW-1:0]     waddr [NPORTS];
  logic [3:0]        wmask [NPORTS];
  logic [NPORTS-1:0] wen;
  logic [NPORTS-1:0] rvalid;
  logic [NPORTS-1:0] hready_w;
  logic [NPORTS-1:0] hresp_w;
  logic [NPORTS*32-1:0] hrdata_w;
  logic              unused_ok;

  assign unused_ok = ^{bus.hburst, bus.hmastlock, bus.hprot};

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    vscale_hasti_sram_port #(
      .NWORDS (NWORDS),
      .AW     (AW)
    ) u_port (
      .hclk    (hclk),
      .hresetn (hresetn),
      .haddr   (bus.haddr[32*i +: 32]),
      .hwrite  (bus.hwrite[i]),
      .hsize   (bus.hsize[3*i +: 3]),
      .htrans  (bus.htrans[2*i +: 2]),
      .hready  (hready_w[i]),
      .hresp   (hresp_w[i]),
      .waddr   (waddr[i]),
      .wmask   (wmask[i]),
      .wen     (wen[i]),
      .rvalid  (rvalid[i])
    );
  end

  assign bus.hready = hready_w;
  assign bus.hresp  = hresp_w;
  assign bus.hrdata = hrdata_w;

  // Highest port first so lower ports overwrite shared lanes
  always_ff @(posedge hclk) begin
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (wen[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[i][b])
            mem[waddr[i]][8*b +: 8] <=
              bus.hwdata[32*i + 8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    hrdata_w = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (rvalid[i])
        hrdata_w[32*i +: 32] = mem[waddr[i]];
    end
  end

endmodule

// File: tb/tb_vscale_hasti_sram_mp.sv
// Bench for the multi-port HASTI SRAM: vector table, directed
// corner sequences and random traffic against a memory model.
module tb_vscale_hasti_sram_mp;

  localparam int NP = 2;
  localparam int NW = 24;

  logic hclk;
  logic hresetn;

  vscale_hasti_sram_mp_if #(.NPORTS(NP)) bus ();

  vscale_hasti_sram_mp #(
    .NPORTS (NP),
    .NWORDS (NW)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // model: 0 none, 1 read data, 2 write data, 3 err1, 4 err2
  int          ph [NP];
  int          pw [NP];
  logic [3:0]  pm [NP];
  logic [31:0] ref_mem [NW];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail < 30)
        $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endfunction

  task automatic set_port(int p, logic [1:0] tr, logic wr,
                          logic [2:0] sz, logic [31:0] a);
    bus.htrans[2*p +: 2] = tr;
    bus.hwrite[p]        = wr;
    bus.hsize[3*p +: 3]  = sz;
    bus.haddr[32*p +: 32] = a;
  endtask

  task automatic set_wd(int p, logic [31:0] d);
    bus.hwdata[32*p +: 32] = d;
  endtask

  function automatic logic [31:0] rd(int p);
    return bus.hrdata[32*p +: 32];
  endfunction

  task automatic model_check();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("mdl.p%0d.hready", p),
          32'(bus.hready[p]), 32'(ph[p] != 3));
      chk($sformatf("mdl.p%0d.hresp", p),
          32'(bus.hresp[p]), 32'(ph[p] >= 3));
      chk($sformatf("mdl.p%0d.hrdata", p), rd(p),
          (ph[p] == 1) ? ref_mem[pw[p]] : 32'h0);
    end
  endtask

  task automatic model_edge();
    int tr, sz, a, nb;
    logic [31:0] wd;
    for (int p = NP - 1; p >= 0; p--) begin
      if (ph[p] == 2) begin
        wd = bus.hwdata[32*p +: 32];
        for (int b = 0; b < 4; b++)
          if (pm[p][b]) ref_mem[pw[p]][8*b +: 8] = wd[8*b +: 8];
      end
    end
    for (int p = 0; p < NP; p++) begin
      tr = int'(bus.htrans[2*p +: 2]);
      sz = int'(bus.hsize[3*p +: 3]);
      a  = int'(bus.haddr[32*p +: 32]);
      if (ph[p] == 3) ph[p] = 4;
      else if (tr == 2 || tr == 3) begin
        if (sz <= 2 && a % (1 << sz) == 0 && a / 4 < NW) begin
          nb = 1 << sz;
          ph[p] = bus.hwrite[p] ? 2 : 1;
          pw[p] = a / 4;
          pm[p] = 4'(((1 << nb) - 1) << (a % 4));
        end else ph[p] = 3;
      end else ph[p] = 0;
    end
  endtask

  task automatic half_a();
    @(negedge hclk);
    model_check();
  endtask

  task automatic half_b();
    @(posedge hclk);
    model_edge();
    #1;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) set_port(p, 2'd0, 1'b0, 3'd2, 0);
  endtask

  task automatic reset_now(string nm);
    hresetn = 1'b0;
    for (int p = 0; p < NP; p++) ph[p] = 0;
    #1;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s.p%0d.hready", nm, p),
          32'(bus.hready[p]), 32'h1);
      chk($sformatf("%s.p%0d.hresp", nm, p),
          32'(bus.hresp[p]), 32'h0);
      chk($sformatf("%s.p%0d.hrdata", nm, p), rd(p), 32'h0);
    end
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rdy;
    logic        rsp;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] old;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] a;

    tbl[0]  = '{2'd2, 1'b1, 3'd2, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{2'd2, 1'b1, 3'd0, 32'h21, 32'hDEADBEEF,
                1'b1, 1'b0, 32'h0};
    tbl[2]  = '{2'd2, 1'b1, 3'd1, 32'h22, 32'h00001100,
                1'b1, 1'b0, 32'h0};
    tbl[3]  = '{2'd2, 1'b0, 3'd2, 32'h20, 32'h22330000,
                1'b1, 1'b0, 32'h0};
    tbl[4]  = '{2'd2, 1'b0, 3'd2, 32'h10, 32'h0,
                1'b1, 1'b0, 32'h22331100};
    tbl[5]  = '{2'd2, 1'b0, 3'd2, 32'h60, 32'h0,
                1'b1, 1'b0, 32'hDEADBEEF};
    tbl[6]  = '{2'd0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0};
    tbl[7]  = '{2'd2, 1'b0, 3'd2, 32'h2, 32'h0, 1'b1, 1'b1, 32'h0};
    tbl[8]  = '{2'd0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0};
    tbl[9]  = '{2'd2, 1'b1, 3'd3, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0};
    tbl[10] = '{2'd0, 1'b0, 3'd2, 32'h0, 32'h12345678,
                1'b0, 1'b1, 32'h0};
    tbl[11] = '{2'd2, 1'b1, 3'd1, 32'h11, 32'h0, 1'b1, 1'b1, 32'h0};
    tbl[12] = '{2'd0, 1'b0, 3'd2, 32'h0, 32'h87654321,
                1'b0, 1'b1, 32'h0};
    tbl[13] = '{2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0};
    tbl[14] = '{2'd1, 1'b0, 3'd2, 32'h20, 32'h0,
                1'b1, 1'b0, 32'hDEADBEEF};
    tbl[15] = '{2'd0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
    tbl[16] = '{2'd0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};

    bus.hburst    = '0;
    bus.hmastlock = '0;
    bus.hprot     = '0;
    bus.hwdata    = '0;
    idle_all();
    for (int p = 0; p < NP; p++) begin
      ph[p] = 0; pw[p] = 0; pm[p] = '0;
    end
    for (int w = 0; w < NW; w++) ref_mem[w] = 32'h0;

    hresetn = 1'b1;
    #2;
    reset_now("rst0");
    @(posedge hclk);
    #1;

    // clear every word so the model starts in step
    for (int w = 0; w < NW; w++) begin
      set_port(0, 2'd2, 1'b1, 3'd2, 32'(4 * w));
      set_wd(0, 32'h0);
      half_a(); half_b();
    end
    idle_all();
    half_a(); half_b();

    for (int i = 0; i < 17; i++) begin
      set_port(0, tbl[i].tr, tbl[i].wr, tbl[i].sz, tbl[i].a);
      set_wd(0, tbl[i].wd);
      half_a();
      chk($sformatf("tbl%0d.hready", i),
          32'(bus.hready[0]), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d.hresp", i),
          32'(bus.hresp[0]), 32'(tbl[i].rsp));
      chk($sformatf("tbl%0d.hrdata", i), rd(0), tbl[i].rdat);
      half_b();
    end

    // P1 reads what P0 wrote
    set_port(1, 2'd2, 1'b0, 3'd2, 32'h10);
    half_a(); half_b();
    idle_all();
    half_a();
    chk("xport.rdata", rd(1), 32'hDEADBEEF);
    chk("xport.hready", 32'(bus.hready[1]), 32'h1);
    chk("xport.hresp", 32'(bus.hresp[1]), 32'h0);
    half_b();

    // simultaneous writes: P0 wins overlapping lanes
    set_port(0, 2'd2, 1'b1, 3'd2, 32'h30);
    set_port(1, 2'd2, 1'b1, 3'd1, 32'h30);
    half_a(); half_b();
    set_wd(0, 32'hAAAAAAAA);
    set_wd(1, 32'h0000BBBB);
    set_port(0, 2'd2, 1'b1, 3'd1, 32'h34);
    set_port(1, 2'd2, 1'b1, 3'd2, 32'h34);
    half_a(); half_b();
    set_wd(0, 32'h00005555);
    set_wd(1, 32'hCCCCCCCC);
    set_port(0, 2'd2, 1'b0, 3'd2, 32'h34);
    set_port(1, 2'd2, 1'b0, 3'd2, 32'h30);
    half_a(); half_b();
    idle_all();
    half_a();
    chk("merge.word", rd(1), 32'hAAAAAAAA);
    chk("merge.half", rd(0), 32'hCCCC5555);
    half_b();

    // read before / with a write data phase to the same word
    set_port(0, 2'd2, 1'b1, 3'd2, 32'h40);
    half_a(); half_b();
    idle_all();
    set_wd(0, 32'h1);
    half_a(); half_b();
    set_port(0, 2'd2, 1'b1, 3'd2, 32'h40);
    set_port(1, 2'd2, 1'b0, 3'd2, 32'h40);
    half_a(); half_b();
    set_port(0, 2'd0, 1'b0, 3'd2, 0);
    set_wd(0, 32'h2);
    half_a();
    chk("order.old", rd(1), 32'h1);
    half_b();
    idle_all();
    half_a();
    chk("order.new", rd(1), 32'h2);
    half_b();

    // reset while in ERR1
    set_port(0, 2'd2, 1'b0, 3'd2, 32'h60);
    half_a(); half_b();
    idle_all();
    half_a();
    chk("rst_err1.pre", 32'(bus.hready[0]), 32'h0);
    reset_now("rst_err1");

    // reset during a write data phase
    old = ref_mem[17];
    set_port(0, 2'd2, 1'b1, 3'd2, 32'h44);
    half_a(); half_b();
    idle_all();
    set_wd(0, 32'h99999999);
    half_a();
    reset_now("rst_wr");
    set_port(0, 2'd2, 1'b0, 3'd2, 32'h44);
    half_a(); half_b();
    idle_all();
    half_a();
    chk("rst_wr.kept", rd(0), old);
    half_b();

    // random traffic on both ports
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) begin
        tr = 2'($urandom_range(0, 3));
        sz = ($urandom_range(0, 9) == 0) ? 3'd3
             : 3'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, NW * 4 + 7));
        if ($urandom_range(0, 9) < 8 && sz <= 3'd2)
          a = a & ~((32'h1 << sz) - 32'h1);
        set_port(p, tr, 1'($urandom_range(0, 1)), sz, a);
        set_wd(p, $urandom);
      end
      half_a(); half_b();
    end
    idle_all();
    half_a(); half_b();

    reset_now("rst_seq");
    // streamed SEQ reads, one word per cycle
    for (int k = 0; k < 9; k++) begin
      if (k < 8)
        set_port(0, (k == 0) ? 2'd2 : 2'd3, 1'b0, 3'd2,
                 32'(4 * k));
      else idle_all();
      half_a();
      if (k > 0) begin
        chk($sformatf("seq%0d.rdata", k - 1), rd(0),
            ref_mem[k - 1]);
        chk($sformatf("seq%0d.hready", k - 1),
            32'(bus.hready[0]), 32'h1);
      end
      half_b();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
